// File: rtl/drive_pkg.sv
// rtl/drive_pkg.sv - shared FSM states, command-bit layout and default timing for drive_cmd_tx
package drive_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic [2:0] CMD_FWD      = 3'd0;
    localparam logic [2:0] CMD_BWD      = 3'd1;
    localparam logic [2:0] CMD_LEFT     = 3'd2;
    localparam logic [2:0] CMD_RIGHT    = 3'd3;
    localparam logic [2:0] CMD_MODE_LSB = 3'd4;

    // 100 MHz system clock into a 9600 baud link
    localparam int DEFAULT_CLKS_PER_BIT   = 10417;
    localparam int DEFAULT_REFRESH_CYCLES = 1000000;

endpackage

// File: rtl/baud_tick.sv
// rtl/baud_tick.sv - bit-period counter; ticks in the last cycle of each UART bit, held at zero by clear
module baud_tick
    import drive_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/drive_cmd_tx.sv
// rtl/drive_cmd_tx.sv - serializes the manual-drive command byte onto the UART TX line
// DRIVE_CMD_TX_PARITY_EN adds an even-parity bit between the data and stop bits
module drive_cmd_tx
    import drive_pkg::*;
#(
    parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
    parameter int REFRESH_CYCLES = DEFAULT_REFRESH_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       move_forward,
    input  logic       move_backward,
    input  logic       turn_left,
    input  logic       turn_right,
    input  logic [1:0] mode,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

    tx_state_t     state, state_next;
    logic [7:0]    cmd_byte, shift_reg, last_sent;
    logic [2:0]    bit_idx;
    logic [RW-1:0] refresh_cnt, refresh_next;
    logic          pending, bit_tick, start_frame;
`ifdef DRIVE_CMD_TX_PARITY_EN
    logic          parity_bit;
`endif

    // Opposing drive or steering requests cancel each other out
    always_comb begin
        cmd_byte                      = '0;
        cmd_byte[CMD_FWD]             = move_forward & ~move_backward;
        cmd_byte[CMD_BWD]             = move_backward & ~move_forward;
        cmd_byte[CMD_LEFT]            = turn_left & ~turn_right;
        cmd_byte[CMD_RIGHT]           = turn_right & ~turn_left;
        cmd_byte[CMD_MODE_LSB +: 2]   = mode;
    end

    assign refresh_next = (refresh_cnt == REFRESH_LAST) ? refresh_cnt : refresh_cnt + 1'b1;
    assign start_frame  = (state == ST_IDLE) && pending && enable;

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state == ST_IDLE),
        .tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            last_sent   <= '0;
            bit_idx     <= '0;
            refresh_cnt <= '0;
            pending     <= 1'b1;
`ifdef DRIVE_CMD_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (start_frame) begin
                shift_reg   <= cmd_byte;
                last_sent   <= cmd_byte;
                bit_idx     <= '0;
                refresh_cnt <= '0;
                pending     <= 1'b0;
`ifdef DRIVE_CMD_TX_PARITY_EN
                parity_bit  <= ^cmd_byte;
`endif
            end else begin
                refresh_cnt <= refresh_next;
                // Sticky until the next frame start, so only the latest value is ever sent
                if ((cmd_byte != last_sent) || (refresh_next == REFRESH_LAST)) begin
                    pending <= 1'b1;
                end
                if ((state == ST_DATA) && bit_tick) begin
                    shift_reg <= {1'b0, shift_reg[7:1]};
                    bit_idx   <= bit_idx + 3'd1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        tx         = 1'b1;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start_frame) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                tx = 1'b0;
                if (bit_tick) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                tx = shift_reg[0];
                if (bit_tick && (bit_idx == 3'd7)) begin
`ifdef DRIVE_CMD_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef DRIVE_CMD_TX_PARITY_EN
            ST_PARITY: begin
                tx = parity_bit;
                if (bit_tick) begin
                    state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    frame_done = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_drive_cmd_tx.sv
// tb/tb_drive_cmd_tx.sv - scoreboard bench for drive_cmd_tx with a line-level frame decoder
module tb_drive_cmd_tx;

    localparam int CPB     = 4;
    localparam int REFRESH = 200;
`ifdef DRIVE_CMD_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n, enable, fwd, bwd, left, right;
    logic [1:0] mode;
    logic       tx, busy, frame_done;

    drive_cmd_tx #(
        .CLKS_PER_BIT  (CPB),
        .REFRESH_CYCLES(REFRESH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .move_forward (fwd),
        .move_backward(bwd),
        .turn_left    (left),
        .turn_right   (right),
        .mode         (mode),
        .tx           (tx),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int         tests = 0, fails = 0;
    int         cyc = 0;
    logic [7:0] edge_cmd = 8'h00;
    logic       edge_rst = 1'b0;
    logic [7:0] exp_q[$];
    int         start_at[$];
    int         started = 0, done = 0, aborted = 0, idle_err = 0;
    bit         in_frame = 1'b0;
    bit         shape_bad = 1'b0;
    int         pos = 0;
    logic [7:0] obs = 8'h00, last_obs = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Command byte from the rules: each direction counts only when its opposite is off
    function automatic logic [7:0] model_cmd(input logic f, input logic b, input logic l,
                                             input logic r, input logic [1:0] m);
        int d;
        d = 0;
        if (f && !b) d += 1;
        if (b && !f) d += 2;
        if (l && !r) d += 4;
        if (r && !l) d += 8;
        d += int'(m) * 16;
        return 8'(d);
    endfunction

    function automatic logic [7:0] cur_cmd();
        return model_cmd(fwd, bwd, left, right, mode);
    endfunction

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
`ifdef DRIVE_CMD_TX_PARITY_EN
        f = {1'b1, 1'($countones(b) % 2), b, 1'b0};
`else
        f = {2'b11, b, 1'b0};
`endif
        return f;
    endfunction

    function automatic int start_of(input int i);
        return (i >= 0 && i < start_at.size()) ? start_at[i] : -1;
    endfunction

    // Edge history: what the DUT saw at each rising edge
    initial forever begin
        @(posedge clk);
        cyc++;
        edge_cmd = cur_cmd();
        edge_rst = rst_n;
    end

    // Predictor pushes the value present at the frame-start edge; decoder pops when the frame ends
    initial forever begin
        logic [10:0] fb;
        int          bi;
        @(negedge clk);
        if (!edge_rst) begin
            if (in_frame) begin
                in_frame = 1'b0;
                aborted++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            check("reset_line", int'({tx, busy, frame_done}), 32'b100);
        end else begin
            if (!in_frame && tx === 1'b0) begin
                in_frame  = 1'b1;
                pos       = 0;
                shape_bad = 1'b0;
                obs       = 8'h00;
                exp_q.push_back(edge_cmd);
                start_at.push_back(cyc);
                started++;
            end
            if (in_frame) begin
                fb = frame_of(exp_q[0]);
                bi = pos / CPB;
                if (tx !== fb[bi] || busy !== 1'b1 || frame_done !== (pos == FRAME_CYC - 1))
                    shape_bad = 1'b1;
                if ((pos % CPB) == CPB / 2 && bi >= 1 && bi <= 8) obs[bi-1] = tx;
                pos++;
                if (pos == FRAME_CYC) begin
                    in_frame = 1'b0;
                    done++;
                    last_obs = obs;
                    check("frame_byte", int'(obs), int'(exp_q.pop_front()));
                    check("frame_shape", int'(shape_bad), 0);
                end
            end else if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
                idle_err++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_start(input string name, input int budget);
        int s0, k;
        s0 = started;
        k  = 0;
        while (started == s0 && k < budget) begin
            step(1);
            k++;
        end
        check(name, int'(started > s0), 1);
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int k, calm;
        k    = 0;
        calm = 0;
        while (calm < 3 && k < budget) begin
            step(1);
            k++;
            if (!in_frame && busy === 1'b0 && (done + aborted) == started) calm++;
            else calm = 0;
        end
        check(name, int'(calm >= 3), 1);
    endtask

    task automatic rand_cmd(input logic [7:0] avoid_a, input logic [7:0] avoid_b);
        logic [5:0] r;
        do begin
            r = 6'($urandom);
        end while (model_cmd(r[0], r[1], r[2], r[3], r[5:4]) == avoid_a ||
                   model_cmd(r[0], r[1], r[2], r[3], r[5:4]) == avoid_b);
        fwd   = r[0];
        bwd   = r[1];
        left  = r[2];
        right = r[3];
        mode  = r[5:4];
    endtask

    initial begin
        int         rel, idx_a, n0, d0, a0;
        logic [7:0] sent_a;

        rst_n = 1'b0; enable = 1'b1;
        fwd = 1'b0; bwd = 1'b0; left = 1'b0; right = 1'b0; mode = 2'b01;
        step(4);
        rst_n = 1'b1;
        rel   = cyc + 1;
        wait_start("reset_frame_start", 5);
        check("reset_latency", start_of(0), rel);
        wait_quiet("quiet_reset_frame", 3 * FRAME_CYC);
        check("byte_10", int'(last_obs), 32'h10);

        fwd = 1'b1; left = 1'b1; mode = 2'b10;
        wait_start("start_25", 6);
        wait_quiet("quiet_25", 3 * FRAME_CYC);
        check("byte_25", int'(last_obs), 32'h25);

        fwd = 1'b1; bwd = 1'b1; left = 1'b0; right = 1'b1; mode = 2'b00;
        wait_start("start_08", 6);
        wait_quiet("quiet_08", 3 * FRAME_CYC);
        check("byte_08", int'(last_obs), 32'h08);

        // Three changes during one frame collapse into a single follow-up frame
        rand_cmd(cur_cmd(), cur_cmd());
        wait_start("start_midframe", 6);
        idx_a  = started - 1;
        sent_a = cur_cmd();
        step(6);
        for (int i = 0; i < 2; i++) begin
            rand_cmd(cur_cmd(), cur_cmd());
            step(7);
        end
        rand_cmd(sent_a, cur_cmd());
        wait_start("start_followup", FRAME_CYC + 10);
        check("b2b_gap", start_of(idx_a + 1) - start_of(idx_a), FRAME_CYC + 1);
        wait_quiet("quiet_followup", 3 * FRAME_CYC);
        check("followup_byte", int'(last_obs), int'(cur_cmd()));
        n0 = started;
        step(100);
        check("single_followup", started, n0);

        n0 = started;
        wait_start("keepalive_1", REFRESH + 20);
        wait_start("keepalive_2", REFRESH + 20);
        check("keepalive_gap_1", start_of(n0) - start_of(n0 - 1), REFRESH);
        check("keepalive_gap_2", start_of(n0 + 1) - start_of(n0), REFRESH);
        wait_quiet("quiet_keepalive", 3 * FRAME_CYC);

        for (int i = 0; i < 6; i++) begin
            rand_cmd(cur_cmd(), cur_cmd());
            wait_start("rand_start", 6);
            wait_quiet("rand_quiet", 3 * FRAME_CYC);
            check("rand_byte", int'(last_obs), int'(cur_cmd()));
        end

        rand_cmd(cur_cmd(), cur_cmd());
        wait_start("start_before_disable", 6);
        d0     = done;
        enable = 1'b0;
        wait_quiet("quiet_disable", 3 * FRAME_CYC);
        check("inflight_completes", done - d0, 1);
        rand_cmd(cur_cmd(), cur_cmd());
        n0 = started;
        step(300);
        check("enable_hold", started, n0);
        enable = 1'b1;
        wait_start("enable_resume", 4);
        wait_quiet("quiet_resume", 3 * FRAME_CYC);
        check("resume_byte", int'(last_obs), int'(cur_cmd()));

        rand_cmd(cur_cmd(), cur_cmd());
        wait_start("start_before_reset", 6);
        step(12);
        d0    = done;
        a0    = aborted;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        rel   = cyc + 1;
        wait_start("restart_after_reset", 5);
        check("reset_abort", aborted - a0, 1);
        check("reset_no_done", done, d0);
        check("restart_latency", start_of(started - 1), rel);
        wait_quiet("quiet_restart", 3 * FRAME_CYC);
        check("restart_byte", int'(last_obs), int'(cur_cmd()));

        check("idle_line", idle_err, 0);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
